// File: rtl/mul_result_stage.sv
// mul_result_stage
// Two-stage post-processor behind the signed 32x32 multiplier. It turns the
// raw signed 64-bit product into the RV32M MUL/MULH/MULHSU/MULHU result.
// A valid/ready pipeline with full backpressure and no bubble feeds writeback.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input handshake for op1, op2, prod, funct, tag_in
//   op1, op2            operands as presented to the multiplier
//   prod                signed 64-bit product op1*op2
//   funct               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   tag_in              opaque tag carried with the operation
//   flush               synchronous kill of both stages
//   out_valid/out_ready output handshake for res and tag_out
//   res, tag_out        selected 32-bit result and its tag
module mul_result_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic [63:0]      prod,
  input  logic [1:0]       funct,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res,
  output logic [TAG_W-1:0] tag_out
);

  logic             v1, v2;
  logic [31:0]      hi_s, lo, c_a, c_b;
  logic [1:0]       f;
  logic [TAG_W-1:0] t;
  logic             adv1, adv2, ld1, ld2;
  logic [31:0]      sel;

  // The ready chain is combinational from out_ready, so a full pipe still
  // accepts a new op in the same cycle that the output drains.
  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  assign ld1 = in_valid & adv1 & ~flush;
  assign ld2 = v1 & adv2 & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  // The multiplier is always signed. An operand treated as unsigned whose
  // top bit is set was read as x - 2^32, so adding the other operand back
  // into the high word restores the unsigned interpretation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_s <= '0;
      lo   <= '0;
      c_a  <= '0;
      c_b  <= '0;
      f    <= '0;
      t    <= '0;
    end else if (ld1) begin
      hi_s <= prod[63:32];
      lo   <= prod[31:0];
      c_a  <= op1[31] ? op2 : 32'd0;
      c_b  <= op2[31] ? op1 : 32'd0;
      f    <= funct;
      t    <= tag_in;
    end
  end

  always_comb begin
    sel = lo;
    case (f)
      2'b00:   sel = lo;
      2'b01:   sel = hi_s;
      2'b10:   sel = hi_s + c_b;
      default: sel = hi_s + c_a + c_b;
    endcase
  end

  // Loading only with a valid S1 entry keeps res stable during stalls and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res     <= '0;
      tag_out <= '0;
    end else if (ld2) begin
      res     <= sel;
      tag_out <= t;
    end
  end

endmodule

// File: tb/tb_mul_result_stage.sv
module tb_mul_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] op1, op2;
  logic [63:0] prod;
  logic [1:0]  funct;
  logic [4:0]  tag_in;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] res;
  logic [4:0]  tag_out;

  mul_result_stage #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .prod(prod), .funct(funct), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  tg;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rnd_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: each RV32M result taken from the matching 64-bit product.
  function automatic logic [31:0] ref_res(logic [31:0] a, logic [31:0] b, logic [1:0] f);
    logic [63:0] sa, sb_, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    case (f)
      2'b00:   p = sa * sb_;
      2'b01:   p = sa * sb_;
      2'b10:   p = sa * zb;
      default: p = za * zb;
    endcase
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: a transfer happens at the next edge whenever valid&ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_tag", {59'd0, tag_out}, 64'h1f_dead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res", res, e.r);
        chk("tag", tag_out, e.tg);
        if (e.lat) chk("latency", cyc + 1 - e.acc, 2);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                      input logic [4:0] tg, input logic [31:0] exp, input bit lat);
    bit ok;
    exp_t e;
    ok = 0;
    op1 = a;
    op2 = b;
    prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    funct = f;
    tag_in = tg;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.r = exp;
      e.tg = tg;
      e.acc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  f;
    logic [31:0] r1;
    logic [4:0]  t1;

    rst = 1'b1;
    in_valid = 0; op1 = 0; op2 = 0; prod = 0; funct = 0; tag_in = 0;
    flush = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_tag", tag_out, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // -1 * 2 under each function, back-to-back
    send(32'hFFFFFFFF, 32'h2, 2'b00, 5'd1, 32'hFFFFFFFE, 1);
    send(32'hFFFFFFFF, 32'h2, 2'b01, 5'd2, 32'hFFFFFFFF, 1);
    send(32'hFFFFFFFF, 32'h2, 2'b10, 5'd3, 32'hFFFFFFFF, 1);
    send(32'hFFFFFFFF, 32'h2, 2'b11, 5'd4, 32'h00000001, 1);
    // 0x80000000 squared
    send(32'h80000000, 32'h80000000, 2'b01, 5'd5, 32'h40000000, 1);
    send(32'h80000000, 32'h80000000, 2'b10, 5'd6, 32'hC0000000, 1);
    send(32'h80000000, 32'h80000000, 2'b11, 5'd7, 32'h40000000, 1);
    send(32'h80000000, 32'h80000000, 2'b00, 5'd8, 32'h00000000, 1);
    drain();

    // Backpressure: 5 x 7 = 35 under MUL
    out_ready = 0;
    send(32'd5, 32'd7, 2'b00, 5'd1, 32'd35, 0);
    send(32'd5, 32'd7, 2'b00, 5'd2, 32'd35, 0);
    op1 = 32'd5; op2 = 32'd7; prod = 64'd35; funct = 0; tag_in = 5'd3; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_tag", tag_out, 1);
      chk("stall_res", res, 35);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    send(32'd5, 32'd7, 2'b00, 5'd3, 32'd35, 0);
    send(32'd5, 32'd7, 2'b00, 5'd4, 32'd35, 0);
    send(32'd5, 32'd7, 2'b00, 5'd5, 32'd35, 0);
    drain();

    // Random operands with random out_ready
    rnd_en = 1;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 16 == 0) a = 32'h80000000;
      if (i % 16 == 1) b = 32'hFFFFFFFF;
      f = 2'($urandom_range(0, 3));
      send(a, b, f, 5'(i), ref_res(a, b, f), 0);
    end
    rnd_en = 0;
    out_ready = 1;
    drain();

    // Flush with both stages full and a new input presented
    out_ready = 0;
    send(32'd3, 32'd3, 2'b00, 5'd10, 32'd9, 0);
    send(32'd3, 32'd3, 2'b00, 5'd11, 32'd9, 0);
    op1 = 32'd3; op2 = 32'd3; prod = 64'd9; tag_in = 5'd12; in_valid = 1; flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    sb.delete();
    out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(32'd6, 32'd7, 2'b00, 5'd13, 32'd42, 1);
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset between edges with both stages full
    out_ready = 0;
    send(32'd2, 32'd4, 2'b00, 5'd20, 32'd8, 0);
    send(32'd2, 32'd4, 2'b00, 5'd21, 32'd8, 0);
    #1;
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_res", res, 0);
    chk("arst_tag", tag_out, 0);
    sb.delete();
    #1;
    rst = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    r1 = ref_res(32'hFFFFFFF0, 32'h00000010, 2'b11);
    t1 = 5'd22;
    send(32'hFFFFFFF0, 32'h00000010, 2'b11, t1, r1, 1);
    drain();
    chk("arst_mulhu_ref", r1, 32'h0000000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_result_stage.md
Name: mul_result_stage

Overview:
- Two-stage pipelined post-processor that sits directly downstream of the combinational 32x32 signed Booth multiplier.
- Captures the raw signed 64-bit product together with the original operands and an RV32M function code.
- Applies the unsigned-operand correction and selects the 32-bit result for MUL, MULH, MULHSU or MULHU.
- Delivers results to the writeback side over a valid/ready handshake with full backpressure.

Parameters:
TAG_W, 5, width of the opaque destination tag carried alongside each operation (e.g. rd index).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  upstream holds a valid product/operand set.
in_ready  output  1  stage can accept this cycle.
op1  input  32  multiplicand as presented to the multiplier.
op2  input  32  multiplier as presented to the multiplier.
prod  input  64  signed product op1*op2, two's complement, from the multiplier.
funct  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
tag_in  input  TAG_W  opaque tag.
flush  input  1  synchronous kill of all in-flight entries.
out_valid  output  1  res/tag_out valid.
out_ready  input  1  downstream accepts.
res  output  32  selected result.
tag_out  output  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1): v1=0, v2=0, out_valid=0, res=0, tag_out=0, all stage-1 registers 0. in_ready=1 once rst deasserts.
- Transfer rule: a transfer occurs on any edge where valid&ready=1, on both the input and the output side.
- Stage advance: adv2 = ~v2 | out_ready; adv1 = ~v1 | adv2; in_ready = adv1. The ready path from out_ready to in_ready is combinational by design, with no bubble.
- Stage 1 (S1), loaded when in_valid&in_ready:
  - hi_s=prod[63:32], lo=prod[31:0].
  - cA = op1[31] ? op2 : 0.
  - cB = op2[31] ? op1 : 0.
  - f=funct, t=tag_in.
  - v1 <= in_valid when adv1; otherwise hold.
- Stage 2 (S2), loaded from S1 when adv2:
  - res <= f==00 ? lo
  - f==01 ? hi_s
  - f==10 ? hi_s + cB
  - f==11 ? hi_s + cA + cB
  - All additions are mod 2^32 (32-bit, carries out discarded).
  - tag_out <= t. v2 <= v1 when adv2.
- Latency: 2 cycles from input transfer to out_valid with out_ready=1. Throughput is 1/cycle sustained.
- Stall: with out_valid=1 and out_ready=0, res/tag_out/S1 hold stable. in_ready=0 iff v1=1 and v2=1.
- Register load gating: when the advancing valid is 0, data registers may load or hold, but res must not change while out_valid=1 and out_ready=0.
- flush=1 (synchronous): next edge v1=0, v2=0. Any input presented that cycle is dropped; in_ready is still driven per the rule above, but no entry is captured. flush has priority over all loads.
- Simultaneous: S2 drain + S1 move + new capture in the same cycle is legal and required.
- Reset mid-operation clears all entries immediately; no partial result emerges.
- The block does no sign/zero extension of operands; the upstream multiplier is always signed and the correction is done here.

Test Plan:
- Reset, then op1=0xFFFFFFFF, op2=0x00000002, prod=0xFFFFFFFF_FFFFFFFE, issued four times with funct 00/01/10/11 back-to-back, out_ready=1 -> res 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 on 4 consecutive cycles starting 2 cycles after the first accept.
- op1=op2=0x80000000, prod=0x40000000_00000000 -> MULH 0x40000000, MULHSU 0xC0000000, MULHU 0x40000000, MUL 0x00000000.
- Backpressure: stream 5 ops (tags 1..5) with out_ready=0 -> in_ready drops after 2 accepts, res/tag_out=1 stable. Release out_ready -> tags 1..5 emerge in order, none lost or duplicated.
- Random out_ready toggling with 1000 random operands and functs -> every res matches the 64-bit reference model selection, in order.
- flush asserted while v1=v2=1 and in_valid=1 -> next cycle out_valid=0, no flushed tag ever appears, and the next accepted op emerges 2 cycles later.
- rst pulsed asynchronously mid-stream between edges -> out_valid and res go to 0 immediately. After release, the first new op returns correctly with latency 2.
